stim_axi_writer: RTL and testbench

- Synthesizable stimulus loader that fills the AXI simulation memory with controlled-system data (temperature, workload, target frequency, power budget, core bindings) before firmware boot.
- Consumes a valid/ready stream of {address, 32-bit data} records, one record per stimulus-file line.
- Issues one single-beat AXI4 write per record onto the external 64-bit AXI data bus and reports progress, completion and errors to the bench/boot controller.
- Sits directly upstream of the AXI sim memory, in place of the per-record behavioural fill task.

---
 rtl/stim_axi_writer_if.sv | 55 +++++
 rtl/stim_axi_writer.sv | 197 +++++++++++++++++++
 tb/tb_stim_axi_writer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_axi_writer_if.sv
// Record stream and single-beat AXI4 write channels shared by the stimulus loader
// (master modport) and its record source / AXI simulation memory (slave modport).
interface stim_axi_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    // Handshake rule on every channel: a transfer completes on the rising clock edge
    // where valid && ready; the source holds its payload stable while valid is high
    // and unaccepted, and ready may depend on valid (never the other way round).
    logic                    rec_valid;
    logic                    rec_ready;
    logic [ADDR_WIDTH-1:0]   rec_addr;
    logic [31:0]             rec_data;

    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;

    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;

    modport master (
        input  rec_valid, rec_addr, rec_data,
        output rec_ready,
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready
    );

    modport slave (
        output rec_valid, rec_addr, rec_data,
        input  rec_ready,
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready
    );
endinterface

// File: rtl/stim_axi_writer.sv
// Stimulus loader: turns a stream of {address, 32-bit word} records into one
// single-beat AXI4 write each, tracking completions, error responses and timeouts.
module stim_axi_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 20,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] num_records_i,
    stim_axi_writer_if.master    bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] wr_count_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic [2:0]           state_dbg_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        ISSUE  = 3'd2,
        WAIT_B = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [CNT_WIDTH-1:0]  wr_cnt_q;
    logic [CNT_WIDTH-1:0]  err_cnt_q;
    logic                  err_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic [TMO_W-1:0]      tmo_q;

    logic rec_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic aw_done_now;
    logic w_done_now;
    logic both_done;
    logic in_flight;
    logic tmo_hit;
    logic last_rec;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Handshake qualifiers; AW and W retire independently of each other.
    assign bus.rec_ready = (state_q == ACCEPT);
    assign bus.aw_valid  = (state_q == ISSUE) && !aw_done_q;
    assign bus.w_valid   = (state_q == ISSUE) && !w_done_q;

    assign rec_fire    = bus.rec_valid && bus.rec_ready;
    assign aw_fire     = bus.aw_valid && bus.aw_ready;
    assign w_fire      = bus.w_valid && bus.w_ready;
    assign aw_done_now = aw_done_q || aw_fire;
    assign w_done_now  = w_done_q || w_fire;
    assign both_done   = aw_done_now && w_done_now;

    // B may land in the same cycle as the last AW/W handshake, so ready opens early.
    assign bus.b_ready = (state_q == WAIT_B) || ((state_q == ISSUE) && both_done);
    assign b_fire      = bus.b_valid && bus.b_ready;

    assign in_flight = (state_q == ISSUE) || (state_q == WAIT_B);
    assign tmo_hit   = in_flight && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign last_rec  = (remaining_q == CNT_WIDTH'(1));

    // Lane steering: bit 2 of the byte address selects the upper 32-bit lane.
    assign bus.aw_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.aw_id    = '0;
    assign bus.aw_len   = 8'd0;
    assign bus.aw_size  = 3'd2;
    assign bus.aw_burst = 2'b01;
    assign bus.w_data   = addr_q[2] ? {data_q, 32'h0000_0000} : {32'h0000_0000, data_q};
    assign bus.w_strb   = addr_q[2] ? 8'hF0 : 8'h0F;
    assign bus.w_last   = 1'b1;

    assign busy_o      = (state_q == ACCEPT) || in_flight;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wr_count_o  = wr_cnt_q;
    assign err_count_o = err_cnt_q;
    assign state_dbg_o = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_records_i == '0) ? FINISH : ACCEPT;
                end
            end
            ACCEPT: begin
                if (rec_fire) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (b_fire) begin
                    state_d = last_rec ? FINISH : ACCEPT;
                end else if (tmo_hit) begin
                    state_d = FINISH;
                end else if (both_done) begin
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_fire) begin
                    state_d = last_rec ? FINISH : ACCEPT;
                end else if (tmo_hit) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wr_cnt_q    <= '0;
            err_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FINISH);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        remaining_q <= num_records_i;
                        wr_cnt_q    <= '0;
                        err_cnt_q   <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (rec_fire) begin
                        addr_q    <= bus.rec_addr;
                        data_q    <= bus.rec_data;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        tmo_q     <= '0;
                    end
                end
                ISSUE, WAIT_B: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (aw_fire) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_fire) begin
                        w_done_q <= 1'b1;
                    end
                    // A completed response wins over a timeout landing in the same cycle.
                    if (b_fire) begin
                        wr_cnt_q    <= sat_inc(wr_cnt_q);
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        if (bus.b_resp != 2'b00) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                            err_q     <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        err_cnt_q <= sat_inc(err_cnt_q);
                        err_q     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_axi_writer.sv
// Randomized scoreboard bench for stim_axi_writer: a record driver, a stalling AXI
// memory model, and a negedge monitor popping expected AW/W beats from queues.
module tb_stim_axi_writer;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int CW  = 20;
  localparam int TMO = 16;
  localparam int XW  = 72;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_records = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] err_count;
  logic [2:0]    state_dbg;

  stim_axi_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  stim_axi_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_records_i(num_records),
    .bus(bus), .busy_o(busy), .done_o(done), .err_o(err),
    .wr_count_o(wr_count), .err_count_o(err_count), .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_aw_q[$];
  logic [XW-1:0] exp_w_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: address word-aligned, 32-bit word placed in lane (addr/4) mod 2.
  function automatic logic [AW-1:0] model_aw(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [XW-1:0] model_w(input logic [31:0] a, input logic [31:0] d);
    int         lane;
    logic [63:0] data;
    logic [7:0]  strb;
    lane = int'((a / 4) % 2);
    data = 64'(d) << (32 * lane);
    strb = 8'h0F << (4 * lane);
    return {strb, data};
  endfunction

  // ---------------- monitor ----------------
  bit prev_rec_fire = 1'b0;
  int rec_ready_seen = 0;
  int aw_seen = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rec_fire = 1'b0;
    end else begin
      if (prev_rec_fire) check("rec_to_issue_latency", {bus.aw_valid, bus.w_valid}, 2'b11);
      prev_rec_fire = bus.rec_valid && bus.rec_ready;
      if (bus.rec_ready) rec_ready_seen++;
      if (bus.aw_valid) aw_seen++;
      if (done) done_seen++;
      if (bus.aw_valid && bus.aw_ready) begin
        if (exp_aw_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL aw_unexpected: got addr %0h with empty expected queue", bus.aw_addr);
        end else begin
          check("aw_addr", bus.aw_addr, exp_aw_q.pop_front());
        end
        check("aw_attr", {bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst},
              {4'h0, 8'h00, 3'd2, 2'b01});
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_w_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w_unexpected: got data %0h with empty expected queue", bus.w_data);
        end else begin
          check("w_beat", {bus.w_strb, bus.w_data}, exp_w_q.pop_front());
        end
        check("w_last", bus.w_last, 1'b1);
      end
    end
  end

  // ---------------- AXI memory model with bounded stalls ----------------
  int max_stall = 0;
  bit b_enable  = 1'b1;
  int err_idx   = -1;
  int b_base    = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw_stall = 0, w_stall = 0, b_stall = 0;

  initial begin
    bit af, wf, bf, rs;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.b_resp   = 2'b00;
    forever begin
      @(negedge clk);
      af = bus.aw_valid && bus.aw_ready;
      wf = bus.w_valid && bus.w_ready;
      bf = bus.b_valid && bus.b_ready;
      rs = rst;
      @(posedge clk); #1;
      if (rs) begin
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_stall = 0; w_stall = 0; b_stall = 0;
      end else begin
        if (af) begin
          bus.aw_ready = 1'b0; aw_cnt++; aw_stall = $urandom_range(0, max_stall);
        end else if (bus.aw_valid && !bus.aw_ready) begin
          if (aw_stall == 0) bus.aw_ready = 1'b1; else aw_stall--;
        end
        if (wf) begin
          bus.w_ready = 1'b0; w_cnt++; w_stall = $urandom_range(0, max_stall);
        end else if (bus.w_valid && !bus.w_ready) begin
          if (w_stall == 0) bus.w_ready = 1'b1; else w_stall--;
        end
        if (bf) begin
          bus.b_valid = 1'b0; b_cnt++; b_stall = $urandom_range(0, max_stall);
        end
        if (!bus.b_valid && b_enable && (((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_cnt)) begin
          if (b_stall == 0) begin
            bus.b_valid = 1'b1;
            bus.b_resp  = ((b_cnt - b_base) == err_idx) ? 2'b10 : 2'b00;
          end else begin
            b_stall--;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_load(input int n);
    done_seen   = 0;
    b_base      = b_cnt;
    num_records = CW'(n);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_record(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.rec_valid = 1'b1;
    bus.rec_addr  = a;
    bus.rec_data  = d;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.rec_ready) begin
        ok = 1'b1;
        exp_aw_q.push_back(model_aw(a));
        exp_w_q.push_back(model_w(a, d));
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL rec_accept_timeout: record addr %0h not accepted within 100 cycles", a);
    end
    @(posedge clk); #1;
    bus.rec_valid = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic finish_load(input string tag, input int exp_wr, input int exp_err);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_done_timeout: no done pulse within 400 cycles", tag);
    end
    check({tag, "_wr_count"}, wr_count, exp_wr);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_err_flag"}, err, exp_err != 0);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    idle_gap(3);
    check({tag, "_done_pulses"}, done_seen, 1);
    check({tag, "_aw_drained"}, exp_aw_q.size(), 0);
    check({tag, "_w_drained"}, exp_w_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_handshakes"}, {bus.rec_ready, bus.aw_valid, bus.w_valid, bus.b_ready}, 4'b0000);
    check({tag, "_status"}, {busy, done, err}, 3'b000);
    check({tag, "_counters"}, {wr_count, err_count}, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dcyc;
    bus.rec_valid = 1'b0;
    bus.rec_addr  = '0;
    bus.rec_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_gap(2);

    // Single record into the upper lane, no stalls.
    max_stall = 0; err_idx = -1; b_enable = 1'b1;
    start_load(1);
    send_record(32'h1C01_0004, 32'hDEAD_BEEF);
    finish_load("single", 1, 0);

    // 1001 random records with stalls; a start pulse mid-load must be ignored.
    max_stall = 5;
    start_load(1001);
    fork
      for (int i = 0; i < 1001; i++) begin
        send_record($urandom, $urandom);
        idle_gap($urandom_range(0, 2));
      end
      begin
        idle_gap(40);
        num_records = CW'(7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    finish_load("stream", 1001, 0);

    // Record 7 of 13 answers SLVERR.
    max_stall = 2; err_idx = 6;
    start_load(13);
    for (int i = 0; i < 13; i++) send_record($urandom, $urandom);
    finish_load("slverr", 13, 1);
    err_idx = -1;

    // Empty load: done two cycles after start, nothing consumed, counters cleared.
    rec_ready_seen = 0; aw_seen = 0; done_seen = 0;
    bus.rec_valid = 1'b1; bus.rec_addr = $urandom; bus.rec_data = $urandom;
    num_records = '0;
    start = 1'b1;
    dcyc = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done && dcyc < 0) dcyc = k;
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.rec_valid = 1'b0;
    check("zero_done_latency", dcyc, 2);
    check("zero_rec_ready", rec_ready_seen, 0);
    check("zero_axi_activity", aw_seen, 0);
    check("zero_done_pulses", done_seen, 1);
    check("zero_counters_cleared", {wr_count, err_count, err}, '0);

    // B never arrives: timeout fires TMO cycles after ISSUE entry.
    b_enable = 1'b0; max_stall = 2;
    start_load(3);
    send_record($urandom, $urandom);
    rec_ready_seen = 0;
    bus.rec_valid = 1'b1; bus.rec_addr = $urandom; bus.rec_data = $urandom;
    dcyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err) begin dcyc = k; break; end
    end
    check("timeout_cycles", dcyc, TMO);
    finish_load("timeout", 0, 1);
    bus.rec_valid = 1'b0;
    check("timeout_no_more_records", rec_ready_seen, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_gap(2);

    // Reset while waiting on B, then a normal 145-record load.
    b_enable = 1'b0; max_stall = 1;
    start_load(5);
    send_record($urandom, $urandom);
    dcyc = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.b_ready) begin dcyc = k; break; end
    end
    check("reached_wait_b", dcyc >= 0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("wait_b_reset");
    @(posedge clk); #1;
    idle_gap(2);
    b_enable = 1'b1; max_stall = 3;
    start_load(145);
    for (int i = 0; i < 145; i++) send_record($urandom, $urandom);
    finish_load("after_reset", 145, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
